// File: rtl/issue_queue.sv
// Circular issue queue between decode and issue: accepts up to two entries per
// cycle, presents the two oldest entries, and retires up to two per cycle.
package issue_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  write_reg;
    logic        write_reg_need;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
  } issue_queue_element_t;
endpackage

module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flash,
  input  issue_queue_element_t [1:0]       push_require,
  input  logic [1:0]                       push_number,
  output logic                             push_ready,
  output issue_queue_element_t [1:0]       issue_require,
  output logic [1:0]                       iq_size,
  input  logic [1:0]                       iq_pop_number,
  output logic [$clog2(DEPTH):0]           count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  issue_queue_element_t r_mem [DEPTH];
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;

  logic                 w_push_ready;
  logic [1:0]           w_iq_size;
  logic [1:0]           w_push_num;
  logic [1:0]           w_push_eff;
  logic [1:0]           w_pop_num;
  logic [1:0]           w_pop_eff;
  logic [PW-1:0]        w_tail_p1;

  // Readiness depends on registered occupancy only, so pops never feed it.
  assign w_push_ready = (r_count <= CW'(DEPTH - 2));
  assign w_iq_size    = (r_count >= CW'(2)) ? 2'd2 : r_count[1:0];

  assign w_push_num = (push_number == 2'd3) ? 2'd2 : push_number;
  assign w_pop_num  = (iq_pop_number == 2'd3) ? 2'd2 : iq_pop_number;
  assign w_push_eff = (w_push_ready && !flash) ? w_push_num : 2'd0;
  assign w_pop_eff  = flash ? 2'd0 : ((w_pop_num < w_iq_size) ? w_pop_num : w_iq_size);
  assign w_tail_p1  = r_tail + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop_eff);
      r_tail  <= r_tail + PW'(w_push_eff);
      r_count <= r_count + CW'(w_push_eff) - CW'(w_pop_eff);
    end
  end

  // Storage is never reset; slots beyond the valid count are masked on output.
  always_ff @(posedge clk) begin
    if (w_push_eff != 2'd0) r_mem[r_tail] <= push_require[0];
    if (w_push_eff == 2'd2) r_mem[w_tail_p1] <= push_require[1];
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_issue_slot
      logic [PW-1:0] w_rd_idx;
      assign w_rd_idx = r_head + PW'(gi);
      assign issue_require[gi] = (w_iq_size > 2'(gi)) ? r_mem[w_rd_idx] : '0;
    end
  endgenerate

  assign push_ready = w_push_ready;
  assign iq_size    = w_iq_size;
  assign count      = r_count;

endmodule

// File: tb/tb_issue_queue.sv
// Randomized self-checking bench for issue_queue against a queue-based model.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                       clk;
  logic                       rst_n;
  logic                       flash;
  issue_queue_element_t [1:0] push_require;
  logic [1:0]                 push_number;
  logic                       push_ready;
  issue_queue_element_t [1:0] issue_require;
  logic [1:0]                 iq_size;
  logic [1:0]                 iq_pop_number;
  logic [CW-1:0]              count;

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flash         (flash),
    .push_require  (push_require),
    .push_number   (push_number),
    .push_ready    (push_ready),
    .issue_require (issue_require),
    .iq_size       (iq_size),
    .iq_pop_number (iq_pop_number),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  issue_queue_element_t mq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] next_pc = 32'h100;
  issue_queue_element_t zero_elem;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic issue_queue_element_t mk_elem(input logic [31:0] pc);
    issue_queue_element_t e;
    e.pc             = pc;
    e.opcode         = 7'($urandom);
    e.write_reg      = 5'($urandom);
    e.write_reg_need = 1'($urandom);
    e.read_reg1      = 5'($urandom);
    e.read_reg2      = 5'($urandom);
    return e;
  endfunction

  // Reference: FIFO semantics straight from the rules, using a SV queue.
  task automatic model_apply(input logic fl, input logic [1:0] pn,
                             input issue_queue_element_t e0, input issue_queue_element_t e1,
                             input logic [1:0] pop);
    int sz;
    int pe;
    int isz;
    int n;
    bit rdy;
    sz  = mq.size();
    rdy = (DEPTH - sz) >= 2;
    if (fl) begin
      mq.delete();
    end else begin
      pe  = (pop > 2) ? 2 : int'(pop);
      isz = (sz < 2) ? sz : 2;
      if (pe > isz) pe = isz;
      repeat (pe) void'(mq.pop_front());
      if (rdy) begin
        n = (pn > 2) ? 2 : int'(pn);
        if (n >= 1) mq.push_back(e0);
        if (n == 2) mq.push_back(e1);
      end
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    issue_queue_element_t x0;
    issue_queue_element_t x1;
    sz = mq.size();
    x0 = (sz >= 1) ? mq[0] : zero_elem;
    x1 = (sz >= 2) ? mq[1] : zero_elem;
    chk({tag, "_count"},      64'(count),      64'(sz));
    chk({tag, "_iq_size"},    64'(iq_size),    64'((sz < 2) ? sz : 2));
    chk({tag, "_push_ready"}, 64'(push_ready), 64'((DEPTH - sz) >= 2));
    chk({tag, "_issue0"},     64'(issue_require[0]), 64'(x0));
    chk({tag, "_issue1"},     64'(issue_require[1]), 64'(x1));
  endtask

  // Drive one cycle of inputs at the falling edge, check after the next rise.
  task automatic step(input string tag, input logic fl, input logic [1:0] pn, input logic [1:0] pop);
    issue_queue_element_t e0;
    issue_queue_element_t e1;
    e0 = mk_elem(next_pc);
    e1 = mk_elem(next_pc + 32'd4);
    flash         = fl;
    push_number   = pn;
    push_require  = {e1, e0};
    iq_pop_number = pop;
    if (!fl && (DEPTH - mq.size()) >= 2)
      next_pc = next_pc + 32'd4 * ((pn > 2'd2) ? 32'd2 : 32'(pn));
    model_apply(fl, pn, e0, e1, pop);
    @(posedge clk);
    @(negedge clk);
    flash         = 1'b0;
    push_number   = 2'd0;
    iq_pop_number = 2'd0;
    check_all(tag);
    chk({tag, "_count_le_depth"}, 64'(count <= CW'(DEPTH)), 64'd1);
  endtask

  initial begin
    zero_elem     = '0;
    rst_n         = 1'b0;
    flash         = 1'b0;
    push_number   = 2'd0;
    iq_pop_number = 2'd0;
    push_require  = '0;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all("post_reset");

    // Single push then dual push with dual pop
    next_pc = 32'h100;
    step("push1", 1'b0, 2'd1, 2'd0);
    chk("push1_pc0", 64'(issue_require[0].pc), 64'h100);
    chk("push1_slot1_zero", 64'(issue_require[1]), 64'd0);
    step("push1b", 1'b0, 2'd1, 2'd0);
    step("push2pop2", 1'b0, 2'd2, 2'd2);
    chk("pp_pc0", 64'(issue_require[0].pc), 64'h108);
    chk("pp_pc1", 64'(issue_require[1].pc), 64'h10C);

    // Fill to full, drop at full, pop to regain space
    step("flash_a", 1'b1, 2'd0, 2'd0);
    for (int i = 0; i < 7; i++) step("fill", 1'b0, 2'd2, 2'd0);
    chk("fill14_count", 64'(count), 64'd14);
    chk("fill14_ready", 64'(push_ready), 64'd1);
    step("fill16", 1'b0, 2'd2, 2'd0);
    chk("full_ready", 64'(push_ready), 64'd0);
    step("drop", 1'b0, 2'd2, 2'd0);
    chk("drop_count", 64'(count), 64'd16);
    step("pop_full", 1'b0, 2'd0, 2'd2);
    chk("pop_full_ready", 64'(push_ready), 64'd1);

    // Wrap-around with alternating push/pop mix
    step("flash_b", 1'b1, 2'd0, 2'd0);
    for (int i = 0; i < 14; i++) begin
      step("wrap_a", 1'b0, 2'd2, 2'd1);
      step("wrap_b", 1'b0, 2'd1, 2'd2);
    end

    // Over-pop clipping
    step("flash_c", 1'b1, 2'd0, 2'd0);
    step("op_push", 1'b0, 2'd1, 2'd0);
    step("op_pop2", 1'b0, 2'd0, 2'd2);
    chk("op_count0", 64'(count), 64'd0);
    step("op_pop_empty", 1'b0, 2'd0, 2'd1);
    step("op_after", 1'b0, 2'd1, 2'd0);

    // Flash with concurrent push/pop
    step("flash_d", 1'b1, 2'd0, 2'd0);
    step("fl_p2a", 1'b0, 2'd2, 2'd0);
    step("fl_p2b", 1'b0, 2'd2, 2'd0);
    step("fl_p1", 1'b0, 2'd1, 2'd0);
    chk("fl_count5", 64'(count), 64'd5);
    step("flash_busy", 1'b1, 2'd2, 2'd1);
    chk("flash_size0", 64'(iq_size), 64'd0);
    next_pc = 32'h500;
    step("fl_sole", 1'b0, 2'd1, 2'd0);
    chk("fl_sole_pc", 64'(issue_require[0].pc), 64'h500);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step("rand", ($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    // Asynchronous reset mid-operation
    while (mq.size() < 3) step("pre_rst", 1'b0, 2'd2, 2'd0);
    flash         = 1'b1;
    push_number   = 2'd2;
    iq_pop_number = 2'd1;
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    check_all("async_rst");
    @(negedge clk);
    flash         = 1'b0;
    push_number   = 2'd0;
    iq_pop_number = 2'd0;
    rst_n         = 1'b1;
    @(negedge clk);
    check_all("rst_release");
    step("after_rst", 1'b0, 2'd2, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
